store_unit_ctrl: RTL and testbench

//  Sequences decoded RISC-V stores (SB/SH/SW) from the execute stage into the data-memory write port.

---
 rtl/store_unit_ctrl_pkg.sv | 27 ++
 rtl/store_buffer_fifo.sv | 72 +++++++
 rtl/store_unit_ctrl.sv | 143 ++++++++++++++
 tb/tb_store_unit_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_unit_ctrl_pkg.sv
// Shared definitions for the store unit: store-control encodings, the drain
// FSM state type and the store-buffer entry layout.
package store_unit_ctrl_pkg;

  localparam int unsigned SU_ADDR_W = 32;
  localparam int unsigned SU_DATA_W = 32;
  localparam int unsigned SU_BE_W   = 4;

  // Store-control encodings presented by decode; anything else is a no-op.
  localparam logic [2:0] STR_NOP = 3'b000;
  localparam logic [2:0] STR_SB  = 3'b001;
  localparam logic [2:0] STR_SH  = 3'b010;
  localparam logic [2:0] STR_SW  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } su_state_e;

  typedef struct packed {
    logic [SU_ADDR_W-1:0] addr;   // word-aligned
    logic [SU_DATA_W-1:0] wdata;  // lane-replicated
    logic [SU_BE_W-1:0]   be;
  } su_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Generic synchronous FIFO of DEPTH entries of type entry_t.
// Ports: push/din write the tail, pop retires the head (dout), count is the
// registered occupancy, full/empty derive from it. Async active-low reset.
// Pushes while full and pops while empty are ignored.
module store_buffer_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic [7:0],
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  output entry_t           dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      // Explicit wrap so DEPTH need not be a power of two.
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/store_unit_ctrl.sv
// Store unit controller: turns decoded SB/SH/SW stores into word-aligned
// memory writes, buffers up to DEPTH of them, and drains them in program
// order over a req/gnt/done handshake.
// Ports: st_valid/st_ready/st_control/rs1_val/rs2_val/imm from execute;
// mem_req/mem_addr/mem_wdata/mem_be/mem_gnt/mem_done to data memory;
// misalign_err/err_addr report dropped misaligned stores;
// sb_empty/sb_count expose buffer occupancy.
module store_unit_ctrl
  import store_unit_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = SU_ADDR_W,
  parameter int unsigned DATA_W = SU_DATA_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_control,
  input  logic [ADDR_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  input  logic [11:0]       imm,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_done,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              sb_empty,
  output logic [CNT_W-1:0]  sb_count
);

  logic [ADDR_W-1:0] ea;
  logic              is_sb, is_sh, is_sw;
  logic              accept, misalign, push, pop;
  su_entry_t         new_entry, head;
  logic [CNT_W-1:0]  count;
  logic              fifo_full, fifo_empty;

  su_state_e         state_q, state_d;
  logic              misalign_err_q, misalign_err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  // Effective address wraps modulo 2^ADDR_W.
  assign ea       = rs1_val + {{(ADDR_W-12){imm[11]}}, imm};
  assign st_ready = !fifo_full;
  assign accept   = st_valid && st_ready;

  always_comb begin
    is_sb = 1'b0;
    is_sh = 1'b0;
    is_sw = 1'b0;
    case (st_control)
      STR_SB:  is_sb = 1'b1;
      STR_SH:  is_sh = 1'b1;
      STR_SW:  is_sw = 1'b1;
      default: ;
    endcase
  end

  assign misalign = (is_sh && ea[0]) || (is_sw && (ea[1:0] != 2'b00));
  assign push     = accept && (is_sb || is_sh || is_sw) && !misalign;

  always_comb begin
    new_entry      = '0;
    new_entry.addr = SU_ADDR_W'({ea[ADDR_W-1:2], 2'b00});
    if (is_sb) begin
      new_entry.be    = 4'b0001 << ea[1:0];
      new_entry.wdata = {4{rs2_val[7:0]}};
    end else if (is_sh) begin
      new_entry.be    = 4'b0011 << ea[1:0];
      new_entry.wdata = {2{rs2_val[15:0]}};
    end else begin
      new_entry.be    = 4'b1111;
      new_entry.wdata = SU_DATA_W'(rs2_val);
    end
  end

  assign pop = (state_q == ST_WAIT) && mem_done;

  store_buffer_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (su_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (new_entry),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    misalign_err_d = accept && misalign;
    err_addr_d     = misalign_err_d ? ea : err_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      misalign_err_q <= 1'b0;
      err_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      misalign_err_q <= misalign_err_d;
      err_addr_q     <= err_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
      ST_REQ:  if (mem_gnt)     state_d = ST_WAIT;
      ST_WAIT: begin
        // Occupancy after this pop is (count - 1 + push).
        if (mem_done) begin
          state_d = ((count > CNT_W'(1)) || push) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == ST_REQ);
    mem_addr  = ADDR_W'(head.addr);
    mem_wdata = DATA_W'(head.wdata);
    mem_be    = head.be;
  end

  assign misalign_err = misalign_err_q;
  assign err_addr     = err_addr_q;
  assign sb_count     = count;
  assign sb_empty     = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_store_unit_ctrl.sv
module tb_store_unit_ctrl;
  import store_unit_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_control;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [11:0] imm;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_done;
  logic        misalign_err;
  logic [31:0] err_addr;
  logic        sb_empty;
  logic [2:0]  sb_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  store_unit_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_control   (st_control),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .imm          (imm),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_gnt      (mem_gnt),
    .mem_done     (mem_done),
    .misalign_err (misalign_err),
    .err_addr     (err_addr),
    .sb_empty     (sb_empty),
    .sb_count     (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one store for one clock edge; the scoreboard learns about it
  // only if it is accepted, is a real store and is naturally aligned.
  task automatic issue(input logic [2:0] ctrl, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [11:0] im,
                       output bit acc);
    logic [31:0] ea;
    logic [1:0]  off;
    exp_t        e;
    ea  = rs1 + {{20{im[11]}}, im};
    off = ea[1:0];
    st_valid   = 1'b1;
    st_control = ctrl;
    rs1_val    = rs1;
    rs2_val    = rs2;
    imm        = im;
    acc        = st_ready;
    e.addr = {ea[31:2], 2'b00};
    if (acc) begin
      if (ctrl == STR_SB) begin
        e.be = 4'b0001 << off; e.wdata = {4{rs2[7:0]}}; q.push_back(e);
      end else if (ctrl == STR_SH && !off[0]) begin
        e.be = 4'b0011 << off; e.wdata = {2{rs2[15:0]}}; q.push_back(e);
      end else if (ctrl == STR_SW && off == 2'b00) begin
        e.be = 4'b1111; e.wdata = rs2; q.push_back(e);
      end
    end
    step();
    st_valid = 1'b0;
  endtask

  // Waits (bounded) for a request and checks it against the scoreboard head,
  // including one stall cycle to confirm the request holds steady.
  task automatic expect_req(input string tag);
    int unsigned n = 0;
    exp_t e;
    while (mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, 64'(mem_req), 64'(1'b1));
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_addr"}, 64'(mem_addr), 64'(e.addr));
      chk({tag, "_be"}, 64'(mem_be), 64'(e.be));
      chk({tag, "_wdata"}, 64'(mem_wdata), 64'(e.wdata));
      step();
      chk({tag, "_hold_req"}, 64'(mem_req), 64'(1'b1));
      chk({tag, "_hold_addr"}, 64'(mem_addr), 64'(e.addr));
    end
  endtask

  task automatic do_gnt(input string tag);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk({tag, "_wait_req_low"}, 64'(mem_req), 64'(1'b0));
  endtask

  task automatic do_done();
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
  endtask

  initial begin
    bit acc;
    int unsigned n_acc;
    rst_n = 1'b0;
    st_valid = 1'b0;
    st_control = STR_NOP;
    rs1_val = '0;
    rs2_val = '0;
    imm = '0;
    mem_gnt = 1'b0;
    mem_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_ready", 64'(st_ready), 64'(1'b1));
    chk("rst_req", 64'(mem_req), 64'(1'b0));
    chk("rst_mis", 64'(misalign_err), 64'(1'b0));
    chk("rst_err_addr", 64'(err_addr), 64'(0));
    chk("rst_empty", 64'(sb_empty), 64'(1'b1));
    chk("rst_count", 64'(sb_count), 64'(0));

    // Single SB and request latency
    issue(STR_SB, 32'h0000_1000, 32'h0000_00AB, 12'd3, acc);
    chk("sb_count", 64'(sb_count), 64'(1));
    chk("sb_req_early", 64'(mem_req), 64'(1'b0));
    step();
    chk("sb_req_latency", 64'(mem_req), 64'(1'b1));
    expect_req("sb");
    do_gnt("sb");
    do_done();
    chk("sb_count_after", 64'(sb_count), 64'(0));
    chk("sb_empty_after", 64'(sb_empty), 64'(1'b1));

    // SH aligned, then SH misaligned
    issue(STR_SH, 32'h0000_2002, 32'h1234_CDEF, 12'hFFE, acc);
    issue(STR_SH, 32'h0000_2002, 32'h1234_CDEF, 12'hFFF, acc);
    chk("mis_pulse", 64'(misalign_err), 64'(1'b1));
    chk("mis_addr", 64'(err_addr), 64'h2001);
    chk("mis_count", 64'(sb_count), 64'(1));
    step();
    chk("mis_pulse_end", 64'(misalign_err), 64'(1'b0));
    chk("mis_addr_hold", 64'(err_addr), 64'h2001);
    expect_req("sh");
    do_gnt("sh");
    do_done();

    // Address wrap, no error
    issue(STR_SW, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 12'd8, acc);
    chk("wrap_no_err", 64'(misalign_err), 64'(1'b0));
    expect_req("wrap");
    do_gnt("wrap");
    do_done();

    // NOP and unknown encodings are dropped silently
    issue(STR_NOP, 32'h0000_3000, 32'h1111_1111, 12'd0, acc);
    issue(3'b111, 32'h0000_3000, 32'h2222_2222, 12'd0, acc);
    chk("nop_count", 64'(sb_count), 64'(0));
    chk("nop_no_err", 64'(misalign_err), 64'(1'b0));
    chk("nop_empty", 64'(sb_empty), 64'(1'b1));

    // Fill the buffer with gnt held low
    n_acc = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      issue(STR_SW, 32'h0000_4000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 12'd0, acc);
      if (acc) n_acc++;
    end
    chk("full_accepts", 64'(n_acc), 64'(DEPTH));
    chk("full_ready", 64'(st_ready), 64'(1'b0));
    chk("full_count", 64'(sb_count), 64'(DEPTH));

    // Pop while full: no same-cycle push
    expect_req("full0");
    do_gnt("full0");
    mem_done = 1'b1;
    chk("full_pop_ready", 64'(st_ready), 64'(1'b0));
    issue(STR_SW, 32'h0000_5000, 32'hBBBB_BBBB, 12'd0, acc);
    mem_done = 1'b0;
    chk("full_pop_count", 64'(sb_count), 64'(DEPTH - 1));
    for (int i = 1; i < DEPTH; i++) begin
      expect_req($sformatf("drain%0d", i));
      do_gnt("drain");
      do_done();
    end
    chk("drain_empty", 64'(sb_empty), 64'(1'b1));

    // Push and pop in the same cycle at count 2
    issue(STR_SW, 32'h0000_6000, 32'hC000_0001, 12'd0, acc);
    issue(STR_SW, 32'h0000_6004, 32'hC000_0002, 12'd0, acc);
    expect_req("pp0");
    do_gnt("pp0");
    chk("pp_count_before", 64'(sb_count), 64'(2));
    mem_done = 1'b1;
    issue(STR_SB, 32'h0000_6008, 32'h0000_0077, 12'd2, acc);
    mem_done = 1'b0;
    chk("pp_count_after", 64'(sb_count), 64'(2));
    expect_req("pp1");
    do_gnt("pp1");
    do_done();
    expect_req("pp2");
    do_gnt("pp2");
    do_done();
    chk("pp_empty", 64'(sb_empty), 64'(1'b1));

    // Async reset while in WAIT with 3 entries
    issue(STR_SW, 32'h0000_7000, 32'hD000_0001, 12'd0, acc);
    issue(STR_SW, 32'h0000_7004, 32'hD000_0002, 12'd0, acc);
    issue(STR_SW, 32'h0000_7008, 32'hD000_0003, 12'd0, acc);
    expect_req("rst0");
    do_gnt("rst0");
    chk("rst_wait_count", 64'(sb_count), 64'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(mem_req), 64'(1'b0));
    chk("arst_count", 64'(sb_count), 64'(0));
    chk("arst_empty", 64'(sb_empty), 64'(1'b1));
    q.delete();
    step();
    rst_n = 1'b1;
    do_done();
    chk("late_done_req", 64'(mem_req), 64'(1'b0));
    chk("late_done_count", 64'(sb_count), 64'(0));
    step();
    chk("late_done_req2", 64'(mem_req), 64'(1'b0));
    chk("late_done_empty", 64'(sb_empty), 64'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
